// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage that sits directly after the execute-stage ALU. It accepts one
// instruction at a time from EX.
//   - Non-memory ops are returned as a registered writeback beat one cycle
//     after they are accepted.
//   - Loads and stores are sent to the data cache over a valid/ready request
//     channel. The cache answers with a single-cycle response pulse.
//   - Store data is replicated across byte lanes, with byte enables that
//     select the target lanes.
//   - Load data is shifted down to bit 0, then sign- or zero-extended.
//   - A misaligned access is dropped and reported with a misalign pulse.
//   - A response that never arrives is aborted after RESP_TIMEOUT cycles in
//     WAIT and reported with a bus_err pulse.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   ex_valid / ex_ready      EX handshake; accept = ex_valid & ex_ready
//   alu_result               effective address (mem ops) or result (others)
//   rs2_data                 store data
//   mem_op                   0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU,
//                            6 SB, 7 SH, 8 SW; codes 9-15 act as NONE
//   rd_addr, reg_write       destination register and its write flag
//   dc_req_*                 cache request: valid, ready, we, word address,
//                            lane-replicated wdata, byte enables
//   dc_resp_valid/rdata      cache response pulse and load word
//   wb_valid/we/rd/data      registered writeback beat
//   misalign, bus_err        single-cycle error pulses
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int RESP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [3:0]  mem_op,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic        dc_req_we,
  output logic [31:0] dc_req_addr,
  output logic [31:0] dc_req_wdata,
  output logic [3:0]  dc_req_be,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_resp_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  // The counter only has to reach RESP_TIMEOUT-1.
  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (RESP_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic        regwr_q;
  logic [CNT_W-1:0] cnt_q;
  logic        wb_valid_q, wb_we_q, misalign_q, bus_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        accept, isLoad, isStore, misaligned, timeoutHit;
  logic [31:0] storeWdata;
  logic [3:0]  storeBe;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // Decode the op that EX presents. This is used only when the op is accepted.
  always_comb begin
    accept     = ex_valid & ex_ready;
    isLoad     = (mem_op >= OP_LB) && (mem_op <= OP_LHU);
    isStore    = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    misaligned = ((mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH) && alu_result[0]) ||
                 ((mem_op == OP_LW || mem_op == OP_SW) && (alu_result[1:0] != 2'b00));
    storeWdata = rs2_data;
    storeBe    = 4'b0000;
    case (mem_op)
      OP_SB: begin
        storeWdata = {4{rs2_data[7:0]}};
        storeBe    = 4'b0001 << alu_result[1:0];
      end
      OP_SH: begin
        storeWdata = {2{rs2_data[15:0]}};
        storeBe    = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        storeWdata = rs2_data;
        storeBe    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte or halfword out of the returned word, then extend
  // it according to the load kind that was captured at accept time.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    loadByte = dc_resp_rdata[7:0];
      2'd1:    loadByte = dc_resp_rdata[15:8];
      2'd2:    loadByte = dc_resp_rdata[23:16];
      default: loadByte = dc_resp_rdata[31:24];
    endcase
    loadHalf = addr_q[1] ? dc_resp_rdata[31:16] : dc_resp_rdata[15:0];
    case (op_q)
      OP_LB:   loadData = {{24{loadByte[7]}}, loadByte};
      OP_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
      OP_LBU:  loadData = {24'd0, loadByte};
      OP_LHU:  loadData = {16'd0, loadHalf};
      OP_LW:   loadData = dc_resp_rdata;
      default: loadData = 32'd0;
    endcase
  end

  assign timeoutHit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A response takes priority over the timeout when both
  // occur in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (isLoad || isStore) && !misaligned) state_d = REQ;
      REQ:  if (dc_req_ready) state_d = WAIT;
      WAIT: if (dc_resp_valid || timeoutHit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on the current state.
  always_comb begin
    ex_ready     = (state_q == IDLE);
    dc_req_valid = (state_q == REQ);
  end

  // Datapath. Capture registers hold the request stable through REQ. The
  // pulse outputs default low so that each one lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      we_q       <= 1'b0;
      rd_q       <= 5'd0;
      regwr_q    <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              misalign_q <= 1'b1;
            end else if (isLoad || isStore) begin
              op_q    <= mem_op;
              addr_q  <= alu_result;
              wdata_q <= storeWdata;
              be_q    <= storeBe;
              we_q    <= isStore;
              rd_q    <= rd_addr;
              regwr_q <= reg_write;
              cnt_q   <= '0;
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= reg_write & (rd_addr != 5'd0);
              wb_rd_q    <= rd_addr;
              wb_data_q  <= alu_result;
            end
          end
        end
        REQ: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dc_resp_valid) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= ~we_q & regwr_q & (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= we_q ? 32'd0 : loadData;
          end else if (timeoutHit) begin
            bus_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dc_req_we    = we_q;
  assign dc_req_addr  = {addr_q[31:2], 2'b00};
  assign dc_req_wdata = wdata_q;
  assign dc_req_be    = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed and random testbench for mem_access_stage, run with a short
// response timeout. Expected results come from simple arithmetic on the
// address, the op code and the data words.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic        dc_req_we;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_wdata;
  logic [3:0]  dc_req_be;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  mem_access_stage #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .mem_op(mem_op),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Watchdog: stop a runaway simulation and report it.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---- reference model ----------------------------------------------------
  function automatic bit modelIsLoad(input int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit modelIsStore(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit modelMisaligned(input int op, input logic [31:0] addr);
    if (op == 2 || op == 5 || op == 7) return (addr % 2) != 0;
    if (op == 3 || op == 8)            return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input int op, input logic [31:0] addr,
                                            input logic [31:0] word);
    int a;
    logic [31:0] b, h;
    a = int'(addr % 4);
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      1:       return (b >= 32'd128) ? b - 32'd256 : b;
      2:       return (h >= 32'd32768) ? h - 32'd65536 : h;
      3:       return word;
      4:       return b;
      5:       return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input int op, input logic [31:0] rs2);
    case (op)
      6:       return (rs2 & 32'hFF) * 32'h0101_0101;
      7:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] modelBe(input int op, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    case (op)
      6:       return 32'(1 << a);
      7:       return 32'(3 << a);
      8:       return 32'd15;
      default: return 32'd0;
    endcase
  endfunction

  // ---- checking -----------------------------------------------------------
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one op and let it be accepted. The task returns at the negedge
  // that follows the accept edge, with ex_valid already dropped.
  task automatic applyStimulus(input int op, input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic regwr);
    @(negedge clk);
    ex_valid   = 1'b1;
    mem_op     = 4'(op);
    alu_result = addr;
    rs2_data   = rs2;
    rd_addr    = rd;
    reg_write  = regwr;
    checkBit("ex_ready_before_accept", ex_ready, 1'b1);
    @(negedge clk);
    ex_valid   = 1'b0;
    alu_result = $urandom;
    rs2_data   = $urandom;
    mem_op     = 4'($urandom_range(0, 15));
    rd_addr    = 5'($urandom);
    reg_write  = 1'($urandom);
  endtask

  // Run one complete op: accept, request phase, response phase, and the
  // checks of the expected outputs at each step.
  task automatic doOp(input int op, input logic [31:0] addr, input logic [31:0] rs2,
                      input logic [4:0] rd, input logic regwr, input logic [31:0] rdata,
                      input int readyDelay, input int respDelay, input bit stray);
    logic [31:0] expAddr, expWdata, expBe;
    bit ld, st;
    ld       = modelIsLoad(op);
    st       = modelIsStore(op);
    expAddr  = addr & 32'hFFFF_FFFC;
    expWdata = modelWdata(op, rs2);
    expBe    = modelBe(op, addr);
    applyStimulus(op, addr, rs2, rd, regwr);
    if (modelMisaligned(op, addr)) begin
      checkBit("misalign_pulse", misalign, 1'b1);
      checkBit("misalign_no_req", dc_req_valid, 1'b0);
      checkBit("misalign_no_wb", wb_valid, 1'b0);
      checkBit("misalign_ex_ready", ex_ready, 1'b1);
      return;
    end
    if (!ld && !st) begin
      checkBit("none_wb_valid", wb_valid, 1'b1);
      checkOutput("none_wb_data", wb_data, addr);
      checkBit("none_wb_we", wb_we, regwr && rd != 5'd0);
      checkOutput("none_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      checkBit("none_no_req", dc_req_valid, 1'b0);
      return;
    end
    checkBit("req_valid", dc_req_valid, 1'b1);
    checkOutput("req_addr", dc_req_addr, expAddr);
    checkBit("req_we", dc_req_we, st);
    checkOutput("req_be", {28'd0, dc_req_be}, expBe);
    if (st) checkOutput("req_wdata", dc_req_wdata, expWdata);
    for (int i = 0; i < readyDelay; i++) begin
      if (stray) dc_resp_valid = 1'($urandom);
      @(negedge clk);
      checkBit("req_hold_valid", dc_req_valid, 1'b1);
      checkOutput("req_hold_addr", dc_req_addr, expAddr);
      checkOutput("req_hold_be", {28'd0, dc_req_be}, expBe);
      if (st) checkOutput("req_hold_wdata", dc_req_wdata, expWdata);
      checkBit("req_hold_no_wb", wb_valid, 1'b0);
    end
    dc_resp_valid = 1'b0;
    dc_req_ready  = 1'b1;
    @(negedge clk);
    dc_req_ready  = 1'b0;
    checkBit("wait_req_dropped", dc_req_valid, 1'b0);
    checkBit("wait_no_wb", wb_valid, 1'b0);
    repeat (respDelay) @(negedge clk);
    dc_resp_rdata = rdata;
    dc_resp_valid = 1'b1;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    dc_resp_rdata = $urandom;
    checkBit("mem_wb_valid", wb_valid, 1'b1);
    checkBit("mem_wb_we", wb_we, ld && regwr && rd != 5'd0);
    checkOutput("mem_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    if (ld) checkOutput("load_wb_data", wb_data, modelLoad(op, addr, rdata));
    checkBit("mem_no_bus_err", bus_err, 1'b0);
    checkBit("mem_ex_ready", ex_ready, 1'b1);
  endtask

  // ---- directed and random sequence ---------------------------------------
  initial begin
    int op;
    logic [31:0] addr;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    alu_result    = 32'd0;
    rs2_data      = 32'd0;
    mem_op        = 4'd0;
    rd_addr       = 5'd0;
    reg_write     = 1'b0;
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkBit("rst_ex_ready", ex_ready, 1'b1);
    checkBit("rst_req_valid", dc_req_valid, 1'b0);
    checkBit("rst_wb_valid", wb_valid, 1'b0);
    checkBit("rst_misalign", misalign, 1'b0);
    checkBit("rst_bus_err", bus_err, 1'b0);
    checkOutput("rst_wb_data", wb_data, 32'd0);

    // Pass-through op, followed by a check that the writeback is one pulse.
    doOp(0, 32'h1234, 32'd0, 5'd5, 1'b1, 32'd0, 0, 0, 0);
    @(negedge clk);
    checkBit("none_pulse_end", wb_valid, 1'b0);

    // Signed and unsigned byte loads from the top byte lane.
    doOp(1, 32'h103, 32'd0, 5'd7, 1'b1, 32'h80FF_0000, 0, 0, 0);
    doOp(4, 32'h103, 32'd0, 5'd7, 1'b1, 32'h80FF_0000, 0, 0, 0);

    // Halfword store to the upper half, with ready held off for three cycles.
    doOp(7, 32'h202, 32'hABCD_1234, 5'd3, 1'b1, 32'd0, 3, 0, 0);

    // Misaligned word load is dropped.
    doOp(3, 32'h101, 32'd0, 5'd4, 1'b1, 32'd0, 0, 0, 0);
    @(negedge clk);
    checkBit("misalign_pulse_end", misalign, 1'b0);
    checkBit("misalign_still_no_req", dc_req_valid, 1'b0);

    // Response timeout, then a late response that must be ignored.
    applyStimulus(3, 32'h40, 32'd0, 5'd9, 1'b1);
    checkBit("to_req_valid", dc_req_valid, 1'b1);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    checkBit("to_wait0_no_err", bus_err, 1'b0);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      checkBit("to_wait_no_err", bus_err, 1'b0);
      checkBit("to_wait_busy", ex_ready, 1'b0);
    end
    @(negedge clk);
    checkBit("to_bus_err", bus_err, 1'b1);
    checkBit("to_no_wb", wb_valid, 1'b0);
    checkBit("to_ex_ready", ex_ready, 1'b1);
    dc_resp_valid = 1'b1;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    checkBit("late_resp_no_wb", wb_valid, 1'b0);
    checkBit("to_err_pulse_end", bus_err, 1'b0);
    doOp(0, 32'hCAFE_0001, 32'd0, 5'd1, 1'b1, 32'd0, 0, 0, 0);

    // Reset while waiting for a response.
    applyStimulus(3, 32'h300, 32'd0, 5'd2, 1'b1);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkBit("rstw_ex_ready", ex_ready, 1'b1);
    checkBit("rstw_req_valid", dc_req_valid, 1'b0);
    checkBit("rstw_wb_valid", wb_valid, 1'b0);
    checkOutput("rstw_req_addr", dc_req_addr, 32'd0);
    dc_resp_valid = 1'b1;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    checkBit("rstw_resp_ignored", wb_valid, 1'b0);
    checkBit("rstw_no_bus_err", bus_err, 1'b0);

    // Random ops across all op codes and address alignments.
    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 15);
      addr = $urandom;
      doOp(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
           $urandom_range(0, 3), $urandom_range(0, TO - 2), 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
